// File: rtl/line_mem_server.sv
// Memory end of the cache line-fill / write-back interface: 64 lines x 4 B,
// critical-word-first read bursts and sequential 4-beat line writes.
`timescale 1ns/1ps
module line_mem_server #(
   parameter int unsigned LATENCY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [7:0] req_addr,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic [1:0] rd_offset,
   output logic       rd_last,
   output logic       wr_ready,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_done
);
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned LW = 6;
   localparam int unsigned OW = 2;
   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  lat_q, lat_d;
   logic [OW-1:0]  cnt_q, cnt_d;
   logic [LW-1:0]  line_q, line_d;
   logic [OW-1:0]  off_q, off_d;
   logic           req_ready_q, req_ready_d;
   logic           rd_valid_q, rd_valid_d;
   logic [DW-1:0]  rd_data_q, rd_data_d;
   logic [OW-1:0]  rd_offset_q, rd_offset_d;
   logic           rd_last_q, rd_last_d;
   logic           wr_ready_q, wr_ready_d;
   logic           wr_done_q, wr_done_d;

   logic [CW-1:0]  lat_last;
   logic           wr_fire;
   logic [OW-1:0]  rd_beat;
   logic [AW-1:0]  rd_addr;
   logic [AW-1:0]  mem_waddr;
   logic [DW-1:0]  mem_wdata_d;

   // Bytes are stored XORed with their address, so a zeroed power-up image reads as mem[i] = i.
   logic [DW-1:0]  mem_q [2**AW];

   assign lat_last    = CW'(LATENCY - 1);
   assign wr_fire     = (state_q == WR_BURST) && wr_ready_q && wr_valid;
   assign mem_waddr   = {line_q, cnt_q};
   assign mem_wdata_d = wr_data ^ mem_waddr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_valid) state_d = req_we ? WR_BURST : RD_WAIT;
         RD_WAIT:  if (lat_q == lat_last) state_d = RD_BURST;
         RD_BURST: if (cnt_q == 2'd3) state_d = IDLE;
         WR_BURST: if (wr_fire && (cnt_q == 2'd3)) state_d = WR_WAIT;
         WR_WAIT:  if (lat_q == lat_last) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Counters, request latch and the next registered value of every output.
   always_comb begin
      lat_d       = lat_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      off_d       = off_q;
      req_ready_d = (state_d == IDLE);
      rd_valid_d  = 1'b0;
      rd_data_d   = '0;
      rd_offset_d = '0;
      rd_last_d   = 1'b0;
      wr_ready_d  = (state_d == WR_BURST);
      wr_done_d   = (state_q == DONE);
      rd_beat     = (state_q == RD_BURST) ? cnt_q + 2'd1 : 2'd0;
      rd_addr     = {line_q, off_q + rd_beat};
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               line_d = req_addr[7:2];
               off_d  = req_addr[1:0];
               lat_d  = '0;
               cnt_d  = '0;
            end
         end
         RD_WAIT, WR_WAIT: lat_d = (lat_q == lat_last) ? '0 : lat_q + CW'(1);
         RD_BURST:         cnt_d = rd_beat;
         WR_BURST:         if (wr_fire) cnt_d = cnt_q + 2'd1;
         default:          ;
      endcase
      if (state_d == RD_BURST) begin
         rd_valid_d  = 1'b1;
         rd_offset_d = rd_addr[1:0];
         rd_data_d   = mem_q[rd_addr] ^ rd_addr;
         rd_last_d   = (rd_beat == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_q       <= '0;
         cnt_q       <= '0;
         line_q      <= '0;
         off_q       <= '0;
         req_ready_q <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_offset_q <= '0;
         rd_last_q   <= 1'b0;
         wr_ready_q  <= 1'b0;
         wr_done_q   <= 1'b0;
      end else begin
         lat_q       <= lat_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
         off_q       <= off_d;
         req_ready_q <= req_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_offset_q <= rd_offset_d;
         rd_last_q   <= rd_last_d;
         wr_ready_q  <= wr_ready_d;
         wr_done_q   <= wr_done_d;
      end
   end

   // Storage is deliberately outside reset.
   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[mem_waddr] <= mem_wdata_d;
   end

   assign req_ready = req_ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_offset = rd_offset_q;
   assign rd_last   = rd_last_q;
   assign wr_ready  = wr_ready_q;
   assign wr_done   = wr_done_q;
endmodule
